// File: rtl/version_readout_ctrl.sv
// Arbitrated readout of the build-version table: round-robin register reads plus a streamed dump.
// Define VERSION_READOUT_CSUM_EN to add an XOR checksum as word 15 (readable, and streamed as the final dump word).
module version_readout_ctrl #(
    parameter int          N_REQ    = 2,
    parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [319:0]         hash_i,
    input  logic [159:0]         ts_i,
    input  logic [N_REQ-1:0]     rd_req_i,
    input  logic [4*N_REQ-1:0]   rd_addr_i,
    output logic [N_REQ-1:0]     rd_gnt_o,
    output logic                 rd_valid_o,
    output logic [31:0]          rd_data_o,
    output logic [2:0]           rd_id_o,
    output logic                 rd_err_o,
    input  logic                 dump_start_i,
    output logic                 dump_busy_o,
    output logic [31:0]          m_tdata,
    output logic                 m_tvalid,
    input  logic                 m_tready,
    output logic                 m_tlast
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DUMP
    } state_t;

`ifdef VERSION_READOUT_CSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd15;
`else
    localparam logic [3:0] LAST_IDX = 4'd14;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_ptr;
    logic [3:0]  r_idx;
    logic [31:0] r_rd_data;
    logic [2:0]  r_rd_id;
    logic        r_rd_err;

    logic [31:0] w_words [16];
    logic        w_gnt_found;
    logic [2:0]  w_gnt_idx;
    logic [3:0]  w_gnt_addr;
    logic        w_grant_fire;
    logic        w_addr_err;
    logic [2:0]  w_ptr_next;
    logic        w_dump_last_hs;

    // Word map: three words per component (hash low, hash high, timestamp).
    always_comb begin
        for (int c = 0; c < 5; c++) begin
            w_words[3*c]     = hash_i[64*c +: 32];
            w_words[3*c + 1] = hash_i[64*c + 32 +: 32];
            w_words[3*c + 2] = ts_i[32*c +: 32];
        end
`ifdef VERSION_READOUT_CSUM_EN
        w_words[15] = '0;
        for (int j = 0; j < 15; j++) begin
            w_words[15] = w_words[15] ^ w_words[j];
        end
`else
        w_words[15] = ERR_WORD;
`endif
    end

    // Round robin: first requester at or after the pointer wins.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_gnt_addr  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_gnt_found && rd_req_i[i] && (i == ((int'(r_ptr) + k) % N_REQ))) begin
                    w_gnt_found = 1'b1;
                    w_gnt_idx   = 3'(i);
                    w_gnt_addr  = rd_addr_i[4*i +: 4];
                end
            end
        end
    end

`ifdef VERSION_READOUT_CSUM_EN
    assign w_addr_err = 1'b0;
`else
    assign w_addr_err = (w_gnt_addr == 4'd15);
`endif

    assign w_ptr_next     = (w_gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : w_gnt_idx + 3'd1;
    assign w_grant_fire   = (r_state == S_IDLE) && !dump_start_i && w_gnt_found;
    assign w_dump_last_hs = (r_state == S_DUMP) && m_tready && (r_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (dump_start_i) begin
                    w_next_state = S_DUMP;
                end else if (w_gnt_found) begin
                    w_next_state = S_READ;
                end
            end
            S_READ: w_next_state = S_IDLE;
            S_DUMP: begin
                if (w_dump_last_hs) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Grant is combinational in the grant cycle; masked by reset so all outputs read 0 while held in reset.
    always_comb begin
        rd_gnt_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rd_gnt_o[i] = rst_n && w_grant_fire && (w_gnt_idx == 3'(i));
        end
        rd_valid_o  = (r_state == S_READ);
        rd_data_o   = r_rd_data;
        rd_id_o     = r_rd_id;
        rd_err_o    = r_rd_err;
        dump_busy_o = (r_state == S_DUMP);
        m_tvalid    = (r_state == S_DUMP);
        m_tlast     = (r_state == S_DUMP) && (r_idx == LAST_IDX);
        m_tdata     = (r_state == S_DUMP) ? w_words[r_idx] : 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_idx     <= '0;
            r_rd_data <= '0;
            r_rd_id   <= '0;
            r_rd_err  <= 1'b0;
        end else begin
            if (w_grant_fire) begin
                r_ptr     <= w_ptr_next;
                r_rd_data <= w_addr_err ? ERR_WORD : w_words[w_gnt_addr];
                r_rd_id   <= w_gnt_idx;
                r_rd_err  <= w_addr_err;
            end
            if ((r_state == S_IDLE) && dump_start_i) begin
                r_idx <= '0;
            end else if ((r_state == S_DUMP) && m_tready) begin
                r_idx <= (r_idx == LAST_IDX) ? 4'd0 : r_idx + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_version_readout_ctrl.sv
// Directed self-checking bench for version_readout_ctrl (N_REQ = 2); honours VERSION_READOUT_CSUM_EN.
module tb_version_readout_ctrl;

`ifdef VERSION_READOUT_CSUM_EN
    localparam int NWORDS = 16;
`else
    localparam int NWORDS = 15;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [319:0] hash_i;
    logic [159:0] ts_i;
    logic [1:0]   rd_req_i;
    logic [7:0]   rd_addr_i;
    logic [1:0]   rd_gnt_o;
    logic         rd_valid_o;
    logic [31:0]  rd_data_o;
    logic [2:0]   rd_id_o;
    logic         rd_err_o;
    logic         dump_start_i;
    logic         dump_busy_o;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic         m_tlast;

    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [31:0] expWords [16];
    logic [31:0] expCsum;

    always #5 clk = ~clk;

    version_readout_ctrl #(
        .N_REQ    (2),
        .ERR_WORD (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hash_i       (hash_i),
        .ts_i         (ts_i),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_gnt_o     (rd_gnt_o),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .rd_id_o      (rd_id_o),
        .rd_err_o     (rd_err_o),
        .dump_start_i (dump_start_i),
        .dump_busy_o  (dump_busy_o),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tlast      (m_tlast)
    );

    task automatic applyReset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        rd_req_i     = 2'b11;
        rd_addr_i    = 8'h00;
        dump_start_i = 1'b1;
        m_tready     = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        nCompared++; if (rd_gnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_gnt: got %b expected 00", rd_gnt_o); end
        nCompared++; if (rd_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", rd_valid_o); end
        nCompared++; if (rd_data_o !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_data: got %h expected 0", rd_data_o); end
        nCompared++; if (dump_busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", dump_busy_o); end
        nCompared++; if (m_tvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_tvalid: got %b expected 0", m_tvalid); end
        nCompared++; if (m_tdata !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_tdata: got %h expected 0", m_tdata); end
        rd_req_i     = 2'b00;
        dump_start_i = 1'b0;
        m_tready     = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        rd_req_i  = 2'b01;
        rd_addr_i = {4'd0, 4'd7};
        #1;
        nCompared++; if (rd_gnt_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL single_gnt: got %b expected 01", rd_gnt_o); end
        @(posedge clk); #1;
        rd_req_i = 2'b00;
        #1;
        nCompared++; if (rd_valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL single_valid: got %b expected 1", rd_valid_o); end
        nCompared++; if (rd_data_o !== 32'h0123_4567) begin nMismatched++; $display("[TB] FAIL single_data: got %h expected 01234567", rd_data_o); end
        nCompared++; if (rd_id_o !== 3'd0) begin nMismatched++; $display("[TB] FAIL single_id: got %0d expected 0", rd_id_o); end
        nCompared++; if (rd_err_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_err: got %b expected 0", rd_err_o); end
        @(posedge clk); #1;
        nCompared++; if (rd_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_valid_drop: got %b expected 0", rd_valid_o); end
        nCompared++; if (rd_data_o !== 32'h0123_4567) begin nMismatched++; $display("[TB] FAIL single_data_hold: got %h expected 01234567", rd_data_o); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  expGnt;
        logic [31:0] expData;
        int          e;
        applyReset();
        rd_addr_i = {4'd3, 4'd0};
        rd_req_i  = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            e       = g % 2;
            expGnt  = (e == 0) ? 2'b01 : 2'b10;
            expData = (e == 0) ? expWords[0] : expWords[3];
            nCompared++; if (rd_gnt_o !== expGnt) begin nMismatched++; $display("[TB] FAIL rr_gnt%0d: got %b expected %b", g, rd_gnt_o, expGnt); end
            nCompared++; if (rd_valid_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL rr_idle_valid%0d: got %b expected 0", g, rd_valid_o); end
            @(posedge clk); #2;
            nCompared++; if (rd_valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL rr_valid%0d: got %b expected 1", g, rd_valid_o); end
            nCompared++; if (rd_id_o !== 3'(e)) begin nMismatched++; $display("[TB] FAIL rr_id%0d: got %0d expected %0d", g, rd_id_o, e); end
            nCompared++; if (rd_data_o !== expData) begin nMismatched++; $display("[TB] FAIL rr_data%0d: got %h expected %h", g, rd_data_o, expData); end
            nCompared++; if (rd_gnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL rr_read_gnt%0d: got %b expected 00", g, rd_gnt_o); end
            if (g == 3) rd_req_i = 2'b00;
            @(posedge clk); #2;
        end
        nCompared++; if (rd_gnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL rr_quiet_gnt: got %b expected 00", rd_gnt_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        logic [31:0] expData;
        logic        expErr;
`ifdef VERSION_READOUT_CSUM_EN
        expData = expCsum;
        expErr  = 1'b0;
`else
        expData = 32'hDEAD_BEEF;
        expErr  = 1'b1;
`endif
        rd_addr_i = {4'd14, 4'd15};
        rd_req_i  = 2'b01;
        #1;
        nCompared++; if (rd_gnt_o !== 2'b01) begin nMismatched++; $display("[TB] FAIL oor_gnt: got %b expected 01", rd_gnt_o); end
        @(posedge clk); #1;
        rd_req_i = 2'b10;
        #1;
        nCompared++; if (rd_valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL oor_valid: got %b expected 1", rd_valid_o); end
        nCompared++; if (rd_data_o !== expData) begin nMismatched++; $display("[TB] FAIL oor_data: got %h expected %h", rd_data_o, expData); end
        nCompared++; if (rd_err_o !== expErr) begin nMismatched++; $display("[TB] FAIL oor_err: got %b expected %b", rd_err_o, expErr); end
        nCompared++; if (rd_gnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL oor_read_gnt: got %b expected 00", rd_gnt_o); end
        @(posedge clk); #2;
        nCompared++; if (rd_gnt_o !== 2'b10) begin nMismatched++; $display("[TB] FAIL edge_gnt: got %b expected 10", rd_gnt_o); end
        @(posedge clk); #1;
        rd_req_i = 2'b00;
        #1;
        nCompared++; if (rd_data_o !== expWords[14]) begin nMismatched++; $display("[TB] FAIL edge_data: got %h expected %h", rd_data_o, expWords[14]); end
        nCompared++; if (rd_err_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL edge_err: got %b expected 0", rd_err_o); end
        nCompared++; if (rd_id_o !== 3'd1) begin nMismatched++; $display("[TB] FAIL edge_id: got %0d expected 1", rd_id_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_dump_backpressure();
        logic        pattern [4];
        logic [31:0] prevData;
        logic        prevStall;
        int          k;
        int          cy;
        pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1;
        k = 0; cy = 0; prevStall = 1'b0; prevData = '0;
        dump_start_i = 1'b1;
        @(posedge clk); #1;
        dump_start_i = 1'b0;
        while (k < NWORDS && cy < 200) begin
            m_tready = pattern[cy % 4];
            #1;
            nCompared++; if (m_tvalid !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_tvalid c%0d: got %b expected 1", cy, m_tvalid); end
            nCompared++; if (dump_busy_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_busy c%0d: got %b expected 1", cy, dump_busy_o); end
            nCompared++; if (m_tdata !== expWords[k]) begin nMismatched++; $display("[TB] FAIL bp_tdata w%0d: got %h expected %h", k, m_tdata, expWords[k]); end
            nCompared++; if (m_tlast !== (k == NWORDS - 1)) begin nMismatched++; $display("[TB] FAIL bp_tlast w%0d: got %b expected %b", k, m_tlast, (k == NWORDS - 1)); end
            if (prevStall) begin
                nCompared++; if (m_tdata !== prevData) begin nMismatched++; $display("[TB] FAIL bp_stable w%0d: got %h expected %h", k, m_tdata, prevData); end
            end
            prevStall = !m_tready;
            prevData  = m_tdata;
            if (m_tready) k++;
            cy++;
            @(posedge clk); #1;
        end
        m_tready = 1'b0;
        #1;
        nCompared++; if (k !== NWORDS) begin nMismatched++; $display("[TB] FAIL bp_handshakes: got %0d expected %0d", k, NWORDS); end
        nCompared++; if (m_tvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_tvalid_end: got %b expected 0", m_tvalid); end
        nCompared++; if (dump_busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_busy_end: got %b expected 0", dump_busy_o); end
        nCompared++; if (m_tlast !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_tlast_end: got %b expected 0", m_tlast); end
        @(posedge clk); #1;
    endtask

    task automatic test_priority();
        int k;
        int cy;
        rd_addr_i    = {4'd4, 4'd0};
        rd_req_i     = 2'b10;
        dump_start_i = 1'b1;
        #1;
        nCompared++; if (rd_gnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL prio_gnt: got %b expected 00", rd_gnt_o); end
        @(posedge clk); #1;
        dump_start_i = 1'b0;
        m_tready     = 1'b1;
        #1;
        k = 0; cy = 0;
        while (k < NWORDS && cy < 100) begin
            nCompared++; if (dump_busy_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL prio_busy w%0d: got %b expected 1", k, dump_busy_o); end
            nCompared++; if (m_tdata !== expWords[k]) begin nMismatched++; $display("[TB] FAIL prio_tdata w%0d: got %h expected %h", k, m_tdata, expWords[k]); end
            nCompared++; if (rd_gnt_o !== 2'b00) begin nMismatched++; $display("[TB] FAIL prio_wait_gnt w%0d: got %b expected 00", k, rd_gnt_o); end
            k++;
            cy++;
            @(posedge clk); #1;
            dump_start_i = (k == 3);
            #1;
        end
        nCompared++; if (dump_busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL prio_busy_end: got %b expected 0", dump_busy_o); end
        nCompared++; if (rd_gnt_o !== 2'b10) begin nMismatched++; $display("[TB] FAIL prio_after_gnt: got %b expected 10", rd_gnt_o); end
        @(posedge clk); #1;
        rd_req_i = 2'b00;
        m_tready = 1'b0;
        #1;
        nCompared++; if (rd_valid_o !== 1'b1) begin nMismatched++; $display("[TB] FAIL prio_valid: got %b expected 1", rd_valid_o); end
        nCompared++; if (rd_id_o !== 3'd1) begin nMismatched++; $display("[TB] FAIL prio_id: got %0d expected 1", rd_id_o); end
        nCompared++; if (rd_data_o !== expWords[4]) begin nMismatched++; $display("[TB] FAIL prio_data: got %h expected %h", rd_data_o, expWords[4]); end
        @(posedge clk); #2;
        nCompared++; if (dump_busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL prio_not_queued: got %b expected 0", dump_busy_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_dump();
        int cy;
        m_tready     = 1'b1;
        dump_start_i = 1'b1;
        @(posedge clk); #1;
        dump_start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        nCompared++; if (m_tdata !== expWords[5]) begin nMismatched++; $display("[TB] FAIL mid_word5: got %h expected %h", m_tdata, expWords[5]); end
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++; if (m_tvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_tvalid: got %b expected 0", m_tvalid); end
        nCompared++; if (dump_busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_busy: got %b expected 0", dump_busy_o); end
        nCompared++; if (m_tdata !== 32'd0) begin nMismatched++; $display("[TB] FAIL mid_tdata: got %h expected 0", m_tdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        nCompared++; if (dump_busy_o !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_idle: got %b expected 0", dump_busy_o); end
        dump_start_i = 1'b1;
        @(posedge clk); #1;
        dump_start_i = 1'b0;
        #1;
        nCompared++; if (m_tvalid !== 1'b1) begin nMismatched++; $display("[TB] FAIL restart_tvalid: got %b expected 1", m_tvalid); end
        nCompared++; if (m_tdata !== expWords[0]) begin nMismatched++; $display("[TB] FAIL restart_word0: got %h expected %h", m_tdata, expWords[0]); end
        cy = 0;
        while (m_tvalid && cy < 40) begin
            @(posedge clk); #1;
            cy++;
        end
        nCompared++; if (cy !== NWORDS) begin nMismatched++; $display("[TB] FAIL restart_len: got %0d expected %0d", cy, NWORDS); end
        m_tready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        hash_i = {64'hA4A4_0044_B4B4_0045, 64'hA3A3_0033_B3B3_0034, 64'h0123_4567_89AB_CDEF,
                  64'hA1A1_0011_B1B1_0012, 64'hA0A0_0001_B0B0_0002};
        ts_i   = {32'h6500_0044, 32'h6500_0033, 32'h6500_0022, 32'h6500_0011, 32'h6500_0000};
        expWords[0]  = 32'hB0B0_0002; expWords[1]  = 32'hA0A0_0001; expWords[2]  = 32'h6500_0000;
        expWords[3]  = 32'hB1B1_0012; expWords[4]  = 32'hA1A1_0011; expWords[5]  = 32'h6500_0011;
        expWords[6]  = 32'h89AB_CDEF; expWords[7]  = 32'h0123_4567; expWords[8]  = 32'h6500_0022;
        expWords[9]  = 32'hB3B3_0034; expWords[10] = 32'hA3A3_0033; expWords[11] = 32'h6500_0033;
        expWords[12] = 32'hB4B4_0045; expWords[13] = 32'hA4A4_0044; expWords[14] = 32'h6500_0044;
        expCsum = '0;
        for (int j = 0; j < 15; j++) expCsum = expCsum ^ expWords[j];
        expWords[15] = expCsum;
        test_reset();
        test_single_read();
        test_round_robin();
        test_out_of_range();
        test_dump_backpressure();
        test_priority();
        test_reset_mid_dump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
